vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator. It replaces the fixed 640x480 sync logic under `vga_top` with one block configurable in resolution, porch/sync widths, sync polarity and system-to-pixel clock ratio. It produces registered sync, blanking and raster-position outputs for the pixel/colour logic and for `vga_top` pins `hSync`/`vSync`. It also produces frame and line strobes that game/state logic uses to update once per frame.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `CLK_DIV`, 4, `ClkPort` cycles per pixel (≥1; 100 MHz → 25 MHz)
- `SYNC_POL`, 0, sync active level (0 = active-low)
- `CW`, 10, width of `hCount`/`vCount`

Ports:
- `ClkPort` in 1: single system clock, all logic on rising edge
- `Reset` in 1: asynchronous, active-high
- `En` in 1: run enable; low freezes all state
- `pixTick` out 1: one-`ClkPort` pixel-rate strobe
- `hCount` out CW: current pixel column, 0..H_TOTAL-1
- `vCount` out CW: current line, 0..V_TOTAL-1
- `hSync` out 1: horizontal sync, level per `SYNC_POL`
- `vSync` out 1: vertical sync, level per `SYNC_POL`
- `bright` out 1: high inside the visible area
- `lineStart` out 1: one-cycle pulse when `hCount` enters 0
- `frameStart` out 1: one-cycle pulse when (`hCount`,`vCount`) enters (0,0)

## Operation
- Totals: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` (800 by default) and `V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP` (525 by default).
- Region order within a line and within a frame: active, front porch, sync, back porch.
- Divider `div` counts 0..CLK_DIV-1 while `En`=1. `pixTick` = (`div`==CLK_DIV-1). With CLK_DIV=1, `pixTick`=`En`.
- On `pixTick`:
  - `hCount` increments; it wraps from H_TOTAL-1 to 0.
  - On that wrap, `vCount` increments; it wraps from V_TOTAL-1 to 0.
- `hSync` is active iff H_ACTIVE+H_FP ≤ `hCount` ≤ H_ACTIVE+H_FP+H_SYNC-1 (656..751 by default).
- `vSync` is active iff V_ACTIVE+V_FP ≤ `vCount` ≤ V_ACTIVE+V_FP+V_SYNC-1 (490..491 by default).
- `bright` = (`hCount`<H_ACTIVE) and (`vCount`<V_ACTIVE).
- Consistency rule: the sync, blanking and strobe outputs are registered, decoded from the next-state counter values. In every cycle they therefore match the `hCount`/`vCount` values presented in that same cycle, with zero skew.
- `lineStart`/`frameStart` fire in the cycle the new count first appears and last exactly one `ClkPort` cycle. A frame wrap asserts both.
- `En`=0: `div`, counters and all outputs hold their values. `pixTick`, `lineStart` and `frameStart` are 0 while `En`=0. Resuming continues from the held position.
- Elaboration must fail if 2^CW < max(H_TOTAL, V_TOTAL), if CLK_DIV < 1, or if any porch/sync parameter is 0.

## Timing
- Reset values:
  - `div`=0, `hCount`=0, `vCount`=0.
  - `hSync`=`vSync`=~SYNC_POL (inactive).
  - `bright`=0, `pixTick`=0, `lineStart`=0, `frameStart`=0.
- First edge after `Reset` falls with `En`=1: `div`=1, or `pixTick` asserts if CLK_DIV=1.
- `bright` becomes valid (1 at (0,0)) on the first edge after `Reset` falls, provided `En`=1.
- Latency: counter change to matching sync/bright change is 0 cycles; both are registered on the same edge.
- Line period is H_TOTAL·CLK_DIV `ClkPort` cycles. Frame period is H_TOTAL·V_TOTAL·CLK_DIV cycles (1,680,000 by default).
- `Reset` mid-line or mid-frame returns everything to the reset values immediately (asynchronously). No `frameStart` is issued for the truncated frame.
- `Reset` has priority over `En`.

## Structure
- Package `vga_timing_pkg`:
  - default 640x480@60 constants
  - `H_TOTAL`/`V_TOTAL` compute functions
  - sync-window bound constants
  - CW sizing helper (clog2)
- Sub-module `clk_en_div`, parametrised by `CLK_DIV`: produces `pixTick` from `ClkPort`, `Reset` and `En`. The same sub-module is reused for button-sampling strobes.
- The counters and output decode stay in the top module.

## Test plan
- Reset: assert `Reset` with `En`=1 → all outputs at the listed reset values. Release → first `pixTick` 4 cycles later (CLK_DIV=4), `bright`=1.
- Default parameters, line check:
  - `hSync` low exactly for `hCount` 656..751.
  - `bright` falls at `hCount`=640.
  - `hCount` wraps from 799 to 0 with `lineStart`=1 and `vCount`+1.
  - Line period 3200 cycles.
- Frame wrap: run to (799,524) → next tick gives (0,0) with `frameStart`=`lineStart`=1 for one cycle. `vSync` low only on lines 490–491.
- Small config (H 4/1/2/1, V 3/1/1/1, CLK_DIV=1, SYNC_POL=1): `hSync` high at `hCount` 5–6, line period 8, frame period 48. A scoreboard model matches every cycle.
- Drop `En` for 50 cycles mid-line at `hCount`=300 → counters and syncs frozen, strobes 0. Resume continues at 300 with no lost or extra pixel.
- Pulse `Reset` asynchronously mid-frame at (400,200) → outputs reset without waiting for a clock edge. Subsequent frame timing is identical to the post-power-up timing.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA raster constants and helpers.
//   - default 640x480@60 porch/sync/active figures
//   - calc_total(): line/frame total from the four region widths
//   - sync_first()/sync_last(): inclusive sync-window bounds
//   - cw_for(): counter width able to hold 0..max(totals)-1
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CLK_DIV  = 4;

  function automatic int unsigned calc_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned sync_first(input int unsigned active, input int unsigned fp);
    return active + fp;
  endfunction

  function automatic int unsigned sync_last(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync);
    return active + fp + sync - 1;
  endfunction

  function automatic int unsigned cw_for(input int unsigned h_total, input int unsigned v_total);
    return $clog2((h_total > v_total) ? h_total : v_total);
  endfunction

  localparam int unsigned DEF_H_TOTAL  = calc_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL  = calc_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  localparam int unsigned DEF_HS_FIRST = sync_first(DEF_H_ACTIVE, DEF_H_FP);
  localparam int unsigned DEF_HS_LAST  = sync_last(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
  localparam int unsigned DEF_VS_FIRST = sync_first(DEF_V_ACTIVE, DEF_V_FP);
  localparam int unsigned DEF_VS_LAST  = sync_last(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);
  localparam int unsigned DEF_CW       = cw_for(DEF_H_TOTAL, DEF_V_TOTAL);

endpackage

// File: rtl/clk_en_div.sv
// clk_en_div: clock-enable divider producing a one-cycle strobe every CLK_DIV
// enabled clocks.
//   clk  in  : system clock (rising edge)
//   rst  in  : asynchronous active-high reset
//   en   in  : run enable; low holds the divider and clears tick
//   tick out : registered strobe, high in the cycle after the divider wrapped
//   adv  out : combinational "wraps on this edge" (en && div==CLK_DIV-1), for
//              logic that must update on the same edge tick is registered
module clk_en_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick,
  output logic adv
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $fatal(1, "clk_en_div: CLK_DIV must be at least 1");
  end

  logic [DW-1:0] div;

  assign adv = en && (div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      div  <= adv ? '0 : div + DW'(1);
      tick <= adv;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//   ClkPort    in  : system clock, all logic on rising edge
//   Reset      in  : asynchronous active-high reset (priority over En)
//   En         in  : run enable; low freezes all state, strobes read 0
//   pixTick    out : one-ClkPort pixel-rate strobe
//   hCount     out : pixel column 0..H_TOTAL-1
//   vCount     out : line 0..V_TOTAL-1
//   hSync      out : horizontal sync, active level SYNC_POL
//   vSync      out : vertical sync, active level SYNC_POL
//   bright     out : high inside the visible area
//   lineStart  out : one-cycle pulse when hCount enters 0
//   frameStart out : one-cycle pulse when (hCount,vCount) enters (0,0)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          ClkPort,
  input  logic          Reset,
  input  logic          En,
  output logic          pixTick,
  output logic [CW-1:0] hCount,
  output logic [CW-1:0] vCount,
  output logic          hSync,
  output logic          vSync,
  output logic          bright,
  output logic          lineStart,
  output logic          frameStart
);

  localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(sync_first(H_ACTIVE, H_FP));
  localparam logic [CW-1:0] HS_LAST  = CW'(sync_last(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CW-1:0] VS_FIRST = CW'(sync_first(V_ACTIVE, V_FP));
  localparam logic [CW-1:0] VS_LAST  = CW'(sync_last(V_ACTIVE, V_FP, V_SYNC));

  localparam longint unsigned COUNT_CAP = 64'd1 << CW;

  if (COUNT_CAP < 64'(H_TOTAL) || COUNT_CAP < 64'(V_TOTAL)) begin : g_bad_cw
    $fatal(1, "vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $fatal(1, "vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
    $fatal(1, "vga_timing_gen: porch and sync widths must be non-zero");
  end

  logic adv;

  clk_en_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
    .clk  (ClkPort),
    .rst  (Reset),
    .en   (En),
    .tick (pixTick),
    .adv  (adv)
  );

  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;
  logic          h_wrap;
  logic          f_wrap;
  logic          hs_next;
  logic          vs_next;
  logic          br_next;

  // Outputs are decoded from the next-state counts and registered on the same
  // edge as the counters, so sync/bright/strobes never lag hCount/vCount.
  always_comb begin
    h_next = hCount;
    v_next = vCount;
    h_wrap = 1'b0;
    f_wrap = 1'b0;
    if (adv) begin
      if (hCount == H_LAST) begin
        h_next = '0;
        h_wrap = 1'b1;
        if (vCount == V_LAST) begin
          v_next = '0;
          f_wrap = 1'b1;
        end else begin
          v_next = vCount + CW'(1);
        end
      end else begin
        h_next = hCount + CW'(1);
      end
    end
    hs_next = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vs_next = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    br_next = (h_next < H_VIS) && (v_next < V_VIS);
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      hCount     <= '0;
      vCount     <= '0;
      hSync      <= ~SYNC_POL;
      vSync      <= ~SYNC_POL;
      bright     <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else if (En) begin
      hCount     <= h_next;
      vCount     <= v_next;
      hSync      <= hs_next;
      vSync      <= vs_next;
      bright     <= br_next;
      lineStart  <= h_wrap;
      frameStart <= f_wrap;
    end else begin
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
//   dut_d : default 640x480 timing, CLK_DIV=4, active-low syncs
//   dut_s : tiny 8x6 raster, CLK_DIV=1, active-high syncs, CW=3
// Both are also compared every cycle against an arithmetic model that derives
// the raster position from the number of enabled clocks since reset.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst_d, rst_s, en_d, en_s;
  logic       pix_d, hs_d, vs_d, br_d, ls_d, fs_d;
  logic [9:0] hc_d, vc_d;
  logic       pix_s, hs_s, vs_s, br_s, ls_s, fs_s;
  logic [2:0] hc_s, vc_s;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen dut_d (
    .ClkPort(clk), .Reset(rst_d), .En(en_d), .pixTick(pix_d),
    .hCount(hc_d), .vCount(vc_d), .hSync(hs_d), .vSync(vs_d),
    .bright(br_d), .lineStart(ls_d), .frameStart(fs_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .SYNC_POL(1'b1), .CW(3)
  ) dut_s (
    .ClkPort(clk), .Reset(rst_s), .En(en_s), .pixTick(pix_s),
    .hCount(hc_s), .vCount(vc_s), .hSync(hs_s), .vSync(vs_s),
    .bright(br_s), .lineStart(ls_s), .frameStart(fs_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned n_d = 0, n_s = 0;
  bit          le_d = 1'b0;

  always @(posedge clk or posedge rst_d) begin
    if (rst_d) begin
      n_d  <= 0;
      le_d <= 1'b0;
    end else begin
      le_d <= en_d;
      if (en_d) n_d <= n_d + 1;
    end
  end

  always @(posedge clk or posedge rst_s) begin
    if (rst_s) n_s <= 0;
    else if (en_s) n_s <= n_s + 1;
  end

  function automatic logic [31:0] exp_def(input int unsigned n, input bit le);
    int unsigned pos, h, v;
    bit pix, ls, fs, hs, vs, br;
    pos = (n / 4) % 420000;
    h   = pos % 800;
    v   = pos / 800;
    pix = le && (n >= 1) && (n % 4 == 0);
    ls  = pix && (h == 0);
    fs  = ls && (v == 0);
    hs  = !((h >= 656) && (h <= 751));
    vs  = !((v >= 490) && (v <= 491));
    br  = (n >= 1) && (h < 640) && (v < 480);
    return {6'b0, pix, ls, fs, hs, vs, br, h[9:0], v[9:0]};
  endfunction

  function automatic logic [31:0] exp_small(input int unsigned n);
    int unsigned pos, h, v;
    bit pix, ls, fs, hs, vs, br;
    pos = n % 48;
    h   = pos % 8;
    v   = pos / 8;
    pix = (n >= 1);
    ls  = pix && (h == 0);
    fs  = ls && (v == 0);
    hs  = (h == 5) || (h == 6);
    vs  = (v == 4);
    br  = (n >= 1) && (h < 4) && (v < 3);
    return {20'b0, pix, ls, fs, hs, vs, br, h[2:0], v[2:0]};
  endfunction

  always @(negedge clk) begin
    if (!done) begin
      chk("sb_default", {6'b0, pix_d, ls_d, fs_d, hs_d, vs_d, br_d, hc_d, vc_d}, exp_def(n_d, le_d));
      chk("sb_small", {20'b0, pix_s, ls_s, fs_s, hs_s, vs_s, br_s, hc_s, vc_s}, exp_small(n_s));
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int  hs_first, hs_last, br_fall, cyc, ls1, ls2, held_v, steps, fs1, fs2, ls_cnt;
    bit  found, prev_br, held_hs;
    logic [7:0] hs_mask;

    rst_d = 1'b1; rst_s = 1'b1; en_d = 1'b1; en_s = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_hcount", hc_d, 0);
    chk("rst_vcount", vc_d, 0);
    chk("rst_hsync", hs_d, 1);
    chk("rst_vsync", vs_d, 1);
    chk("rst_bright", br_d, 0);
    chk("rst_pixtick", pix_d, 0);
    chk("rst_linestart", ls_d, 0);
    chk("rst_framestart", fs_d, 0);
    chk("rst_small_syncs", {hs_s, vs_s}, 2'b00);

    rst_d = 1'b0; rst_s = 1'b0;
    @(negedge clk);
    chk("first_edge_bright", br_d, 1);
    chk("first_edge_pixtick", pix_d, 0);
    chk("small_first_pixtick", pix_s, 1);
    repeat (2) @(negedge clk);
    chk("edge3_pixtick", pix_d, 0);
    @(negedge clk);
    chk("edge4_pixtick", pix_d, 1);
    chk("edge4_hcount", hc_d, 1);

    // Line structure over two full lines
    hs_first = -1; hs_last = -1; br_fall = -1; cyc = 0; ls1 = -1; ls2 = -1;
    prev_br = 1'b1;
    for (int i = 0; i < 8000 && ls2 < 0; i++) begin
      @(negedge clk);
      cyc++;
      if (!hs_d && hs_first < 0) hs_first = int'(hc_d);
      if (!hs_d) hs_last = int'(hc_d);
      if (prev_br && !br_d && br_fall < 0) br_fall = int'(hc_d);
      prev_br = br_d;
      if (ls_d) begin
        if (ls1 < 0) begin
          ls1 = cyc;
          chk("wrap_hcount", hc_d, 0);
          chk("wrap_vcount", vc_d, 1);
        end else begin
          ls2 = cyc;
        end
      end
    end
    chk("hsync_first_col", hs_first, 656);
    chk("hsync_last_col", hs_last, 751);
    chk("bright_fall_col", br_fall, 640);
    chk("line_period", ls2 - ls1, 3200);

    // Freeze at hCount=300 for 50 clocks
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (hc_d == 10'd300 && pix_d) found = 1'b1;
    end
    chk("reach_col_300", found, 1);
    held_hs = hs_d;
    held_v  = int'(vc_d);
    en_d = 1'b0;
    @(negedge clk);
    chk("freeze_pixtick", pix_d, 0);
    chk("freeze_hcount_first", hc_d, 300);
    repeat (49) @(negedge clk);
    chk("freeze_hcount", hc_d, 300);
    chk("freeze_vcount", vc_d, held_v);
    chk("freeze_hsync", hs_d, held_hs);
    chk("freeze_strobes", {pix_d, ls_d, fs_d}, 3'b000);
    en_d = 1'b1;
    steps = 0;
    for (int i = 0; i < 20 && hc_d == 10'd300; i++) begin
      @(negedge clk);
      steps++;
    end
    chk("resume_steps", steps, 4);
    chk("resume_hcount", hc_d, 301);

    // Asynchronous reset mid-line
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (hc_d == 10'd400) found = 1'b1;
    end
    chk("reach_col_400", found, 1);
    #3 rst_d = 1'b1;
    #1;
    chk("async_rst_hcount", hc_d, 0);
    chk("async_rst_vcount", vc_d, 0);
    chk("async_rst_outs", {hs_d, vs_d, br_d, pix_d, ls_d, fs_d}, 6'b110000);
    @(negedge clk);
    rst_d = 1'b0;
    cyc = 0;
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      cyc++;
      if (ls_d) found = 1'b1;
    end
    chk("post_rst_first_line", cyc, 3200);
    chk("post_rst_first_line_v", vc_d, 1);

    // Small raster: frame period, lines per frame, hSync columns
    fs1 = -1; fs2 = -1; ls_cnt = 0; hs_mask = '0;
    for (int i = 0; i < 200 && fs2 < 0; i++) begin
      @(negedge clk);
      if (fs_s) begin
        if (fs1 < 0) fs1 = i;
        else fs2 = i;
      end
      if (fs1 >= 0 && fs2 < 0) begin
        if (hs_s) hs_mask[hc_s] = 1'b1;
        if (ls_s) ls_cnt++;
      end
    end
    chk("small_frame_period", fs2 - fs1, 48);
    chk("small_lines_per_frame", ls_cnt, 6);
    chk("small_hsync_cols", hs_mask, 8'h60);

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
